// File: rtl/dmem_if.sv
// Data-memory port between the pipeline M stage (master) and the
// memory responder (slave). Signal names follow the pipeline's M-stage names.
interface dmem_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MemErrM;

  modport master (
    output MemReadM,
    output MemWriteM,
    output ALUOutM,
    output WriteDataM,
    input  ReadDataM,
    input  MemStallM,
    input  MemErrM
  );

  modport slave (
    input  MemReadM,
    input  MemWriteM,
    input  ALUOutM,
    input  WriteDataM,
    output ReadDataM,
    output MemStallM,
    output MemErrM
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM behind the pipeline M-stage port,
// with a programmable wait-state FSM that stalls the pipeline until each
// access completes.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (trap misaligned accesses:
// flag MemErrM at completion, suppress stores, return 0 on loads).
// Stall, read data and error flag are combinational so the hazard unit sees
// the stall in the same cycle the request is presented. Reset forces them low
// asynchronously.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave mem_if
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [31:0]             mem_q [DEPTH];

  logic                    req_s;
  logic                    mis_s;
  logic                    stall_s;
  logic                    complete_s;
  logic                    we_s;
  logic [DEPTH_LOG2-1:0]   idx_s;
  logic [31:0]             rdata_s;

  assign req_s = mem_if.MemReadM | mem_if.MemWriteM;
  // Upper address bits beyond the array are dropped, so addresses wrap.
  assign idx_s = mem_if.ALUOutM[DEPTH_LOG2+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_s = req_s & (mem_if.ALUOutM[1:0] != 2'b00);
`else
  assign mis_s = 1'b0;
`endif

  // Wait-state sequencing: decide stall, completion and next state/count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_s    = 1'b0;
    complete_s = 1'b0;
    if (reset) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!req_s) begin
            state_d = ST_IDLE;
          end else if (ZERO_WAIT) begin
            complete_s = 1'b1;
          end else begin
            stall_s = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
        ST_WAIT: begin
          if (!req_s) begin
            // Pipeline flush: abandon the access without writing.
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_q != 4'd0) begin
            stall_s = 1'b1;
            cnt_d   = cnt_q - 4'd1;
          end else begin
            complete_s = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A store commits only at its completion edge, never while stalling.
  assign we_s = complete_s & mem_if.MemWriteM & ~mis_s;

  // RAM array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[idx_s] <= mem_if.WriteDataM;
    end
  end

  // Load data: pre-write array contents in the completion cycle, else zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (complete_s && mem_if.MemReadM && !mis_s) begin
      rdata_s = mem_q[idx_s];
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign mem_if.ReadDataM = rdata_s;
  assign mem_if.MemStallM = stall_s;
  assign mem_if.MemErrM   = complete_s & mis_s;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance carries
// most traffic, a WAIT_CYCLES=0 instance covers single-cycle behaviour.
// Expected load data is queued when a request is driven and compared at
// completion.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_if ifa ();
  dmem_if ifb ();

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk    (clk),
    .reset  (reset),
    .mem_if (ifa.slave)
  );

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk    (clk),
    .reset  (reset),
    .mem_if (ifb.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [64];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_a();
    ifa.MemReadM   = 1'b0;
    ifa.MemWriteM  = 1'b0;
    ifa.ALUOutM    = 32'h0;
    ifa.WriteDataM = 32'h0;
  endtask

  task automatic idle_b();
    ifb.MemReadM   = 1'b0;
    ifb.MemWriteM  = 1'b0;
    ifb.ALUOutM    = 32'h0;
    ifb.WriteDataM = 32'h0;
  endtask

  // One full access on the 2-wait-state instance; request is left asserted
  // so a following call is presented back-to-back.
  task automatic access_a(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata);
    int          stalls;
    logic        trap;
    logic [5:0]  idx;
    logic [31:0] exp_rd;
    @(negedge clk);
    ifa.MemReadM   = rd;
    ifa.MemWriteM  = wr;
    ifa.ALUOutM    = addr;
    ifa.WriteDataM = wdata;
    idx = addr[7:2];
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = (addr[1:0] != 2'b00);
`else
    trap = 1'b0;
`endif
    if (rd) exp_q.push_back(trap ? 32'h0 : model[idx]);
    if (wr && !trap) model[idx] = wdata;
    stalls = 0;
    #1;
    while (ifa.MemStallM === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check_eq({tag, "_stalls"}, 32'(stalls), 32'd2);
    check_eq({tag, "_err"}, {31'd0, ifa.MemErrM}, {31'd0, trap});
    if (rd) begin
      exp_rd = exp_q.pop_front();
      check_eq({tag, "_rdata"}, ifa.ReadDataM, exp_rd);
    end
  endtask

  initial begin
    logic [31:0] exp_rd;
    reset = 1'b1;
    idle_a();
    idle_b();
    #12;
    check_eq("rst_stall_a", {31'd0, ifa.MemStallM}, 32'd0);
    check_eq("rst_rdata_a", ifa.ReadDataM, 32'h0);
    check_eq("rst_err_a",   {31'd0, ifa.MemErrM}, 32'd0);
    check_eq("rst_stall_b", {31'd0, ifb.MemStallM}, 32'd0);
    check_eq("rst_rdata_b", ifb.ReadDataM, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Preload and basic store/load.
    access_a("pre00", 1'b0, 1'b1, 32'h00, 32'h0000_0000);
    access_a("pre08", 1'b0, 1'b1, 32'h08, 32'h0000_0808);
    access_a("pre10", 1'b0, 1'b1, 32'h10, 32'h1111_0010);
    access_a("st20",  1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF);
    access_a("ld20",  1'b1, 1'b0, 32'h20, 32'h0);

    // Reset in the middle of a store to 0x10.
    @(negedge clk);
    ifa.MemReadM   = 1'b0;
    ifa.MemWriteM  = 1'b1;
    ifa.ALUOutM    = 32'h10;
    ifa.WriteDataM = 32'hBAD0_BAD0;
    #1;
    check_eq("rstmid_stall_pre", {31'd0, ifa.MemStallM}, 32'd1);
    @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_eq("rstmid_stall_async", {31'd0, ifa.MemStallM}, 32'd0);
    @(negedge clk);
    idle_a();
    reset = 1'b0;
    access_a("ld10_after_rst", 1'b1, 1'b0, 32'h10, 32'h0);

    // Abort: store dropped after one stall cycle.
    @(negedge clk);
    ifa.MemReadM   = 1'b0;
    ifa.MemWriteM  = 1'b1;
    ifa.ALUOutM    = 32'h08;
    ifa.WriteDataM = 32'h0000_0055;
    #1;
    check_eq("abort_stall1", {31'd0, ifa.MemStallM}, 32'd1);
    @(negedge clk);
    ifa.MemWriteM = 1'b0;
    #1;
    check_eq("abort_stall0", {31'd0, ifa.MemStallM}, 32'd0);
    access_a("ld08_after_abort", 1'b1, 1'b0, 32'h08, 32'h0);

    // Wrap plus read/write together: write wins, read shows old data.
    access_a("dual100", 1'b1, 1'b1, 32'h100, 32'h0000_00A5);
    access_a("ld000",   1'b1, 1'b0, 32'h000, 32'h0);

    // Misaligned store to 0x22 (index 8).
    access_a("st22_mis", 1'b0, 1'b1, 32'h22, 32'h0000_0077);
    access_a("ld20_mis", 1'b1, 1'b0, 32'h20, 32'h0);

    // Back-to-back loads.
    access_a("b2b_ld10", 1'b1, 1'b0, 32'h10, 32'h0);
    access_a("b2b_ld08", 1'b1, 1'b0, 32'h08, 32'h0);
    @(negedge clk);
    idle_a();

    // Single-cycle instance: store then load back-to-back.
    @(negedge clk);
    ifb.MemWriteM  = 1'b1;
    ifb.ALUOutM    = 32'h04;
    ifb.WriteDataM = 32'h0000_0011;
    #1;
    check_eq("w0_st_stall", {31'd0, ifb.MemStallM}, 32'd0);
    @(negedge clk);
    ifb.MemWriteM = 1'b0;
    ifb.MemReadM  = 1'b1;
    exp_q.push_back(32'h0000_0011);
    #1;
    check_eq("w0_ld_stall", {31'd0, ifb.MemStallM}, 32'd0);
    exp_rd = exp_q.pop_front();
    check_eq("w0_ld_rdata", ifb.ReadDataM, exp_rd);
    @(negedge clk);
    idle_b();
    #1;
    check_eq("w0_idle_rdata", ifb.ReadDataM, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
